// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the D-stage hazard controller: field widths, MDU latencies and
// the MIPS SPECIAL-opcode funct codes that identify multiply/divide instructions.
package hazard_ctrl_pkg;

  localparam int unsigned TW_DEF       = 2;
  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;
  localparam int unsigned CW_DEF       = 4;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  typedef enum logic [5:0] {
    FnMfhi  = 6'h10,
    FnMthi  = 6'h11,
    FnMflo  = 6'h12,
    FnMtlo  = 6'h13,
    FnMult  = 6'h18,
    FnMultu = 6'h19,
    FnDiv   = 6'h1a,
    FnDivu  = 6'h1b
  } md_funct_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: D-stage sources, E/M destinations,
// MDU start handshake and the stall/MDU status outputs.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned TW = TW_DEF
) ();

  logic [4:0]    D_rs;
  logic [4:0]    D_rt;
  logic          D_rs_used;
  logic          D_rt_used;
  logic [TW-1:0] D_tuse_rs;
  logic [TW-1:0] D_tuse_rt;
  logic          D_md;
  logic [4:0]    E_dst;
  logic [4:0]    M_dst;
  logic [TW-1:0] E_tnew;
  logic [TW-1:0] M_tnew;
  logic          E_md_start;
  logic          E_md_div;
  logic          stall;
  logic          md_busy;
  logic          md_done;
  logic [31:0]   stall_cnt;

  modport master (
    output D_rs, D_rt, D_rs_used, D_rt_used, D_tuse_rs, D_tuse_rt, D_md,
    output E_dst, M_dst, E_tnew, M_tnew, E_md_start, E_md_div,
    input  stall, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, D_rs_used, D_rt_used, D_tuse_rs, D_tuse_rt, D_md,
    input  E_dst, M_dst, E_tnew, M_tnew, E_md_start, E_md_div,
    output stall, md_busy, md_done, stall_cnt
  );

endinterface

// File: rtl/md_busy_timer.sv
// Multiply/divide unit busy timer: loads the operation latency on an accepted start,
// counts down to zero and pulses done on the cycle after the last busy cycle.
module md_busy_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CW       = CW_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;

  always_comb begin
    count_d = count_q;
    if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end else if (start) begin
      // A start while counting is ignored; only an idle unit accepts a new operation.
      count_d = is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end
    done_d = (count_q == CW'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign busy = (count_q != '0);
  assign done = done_q;

endmodule

// File: rtl/hazard_ctrl.sv
// D-stage hazard controller: combinational RAW/MDU stall decision, MDU busy tracking
// and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned TW       = TW_DEF,
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CW       = CW_DEF
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  logic [TW-1:0] tuse_rs, tuse_rt, e_tnew, m_tnew;
  logic          stall_rs, stall_rt, md_stall, stall;
  logic          md_busy, md_done;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  assign tuse_rs = bus.D_tuse_rs;
  assign tuse_rt = bus.D_tuse_rt;
  assign e_tnew  = bus.E_tnew;
  assign m_tnew  = bus.M_tnew;

  // $0 is never a hazard, so a zero source can never match a "no destination" encoding.
  always_comb begin
    stall_rs = bus.D_rs_used && (bus.D_rs != 5'd0) &&
               (((bus.D_rs == bus.E_dst) && (tuse_rs < e_tnew)) ||
                ((bus.D_rs == bus.M_dst) && (tuse_rs < m_tnew)));
    stall_rt = bus.D_rt_used && (bus.D_rt != 5'd0) &&
               (((bus.D_rt == bus.E_dst) && (tuse_rt < e_tnew)) ||
                ((bus.D_rt == bus.M_dst) && (tuse_rt < m_tnew)));
    md_stall = bus.D_md && (md_busy || bus.E_md_start);
    stall    = stall_rs || stall_rt || md_stall;
  end

  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CW       (CW)
  ) u_md_busy_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (bus.E_md_start),
    .is_div (bus.E_md_div),
    .busy   (md_busy),
    .done   (md_done)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.md_busy   = md_busy;
  assign bus.md_done   = md_done;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed corner cases plus random traffic
// compared against a cycle-window model of the MDU and a rule-level hazard model.
module tb_hazard_ctrl;

  localparam int MULT_L = 5;
  localparam int DIV_L  = 10;

  logic clk;
  logic reset;

  hazard_ctrl_if #(.TW(2)) bus ();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Model state: busy spans cycles up to busy_end, done fires at done_cyc.
  int          cyc;
  int          busy_end;
  int          done_cyc;
  logic [31:0] cnt_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit src_hazard(input int r, input bit used, input int tuse);
    int ed, md, et, mt;
    ed = int'(bus.E_dst);
    md = int'(bus.M_dst);
    et = int'(bus.E_tnew);
    mt = int'(bus.M_tnew);
    if (!used || r == 0) return 1'b0;
    return (r == ed && tuse < et) || (r == md && tuse < mt);
  endfunction

  task automatic clear_inputs();
    bus.D_rs = '0; bus.D_rt = '0; bus.D_rs_used = 0; bus.D_rt_used = 0;
    bus.D_tuse_rs = '0; bus.D_tuse_rt = '0; bus.D_md = 0;
    bus.E_dst = '0; bus.M_dst = '0; bus.E_tnew = '0; bus.M_tnew = '0;
    bus.E_md_start = 0; bus.E_md_div = 0;
  endtask

  // Inputs are already applied; check this cycle, then advance the model across the edge.
  task automatic step();
    bit busy_e, done_e, stall_e;
    #1;
    if (!reset) begin
      busy_end = -1;
      done_cyc = -1;
      cnt_m    = '0;
    end
    busy_e  = (cyc <= busy_end);
    done_e  = (cyc == done_cyc);
    stall_e = src_hazard(int'(bus.D_rs), bus.D_rs_used, int'(bus.D_tuse_rs)) ||
              src_hazard(int'(bus.D_rt), bus.D_rt_used, int'(bus.D_tuse_rt)) ||
              (bus.D_md && (busy_e || bus.E_md_start));
    check("stall",     32'(bus.stall),   32'(stall_e));
    check("md_busy",   32'(bus.md_busy), 32'(busy_e));
    check("md_done",   32'(bus.md_done), 32'(done_e));
    check("stall_cnt", bus.stall_cnt,    cnt_m);
    @(posedge clk);
    if (reset) begin
      if (stall_e && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
      if (bus.E_md_start && !busy_e) begin
        busy_end = cyc + (bus.E_md_div ? DIV_L : MULT_L);
        done_cyc = busy_end + 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic set_load_use(input int tnew);
    bus.E_dst = 5'd8; bus.E_tnew = 2'(tnew);
    bus.D_rs = 5'd8; bus.D_rs_used = 1; bus.D_tuse_rs = 2'd1;
  endtask

  initial begin
    int nb;
    n_vec = 0; n_err = 0;
    cyc = 0; busy_end = -1; done_cyc = -1; cnt_m = '0;
    reset = 0;
    clear_inputs();

    // Stall stays combinational while reset is held; counters stay cleared.
    set_load_use(2);
    #1 check("stall_in_reset", 32'(bus.stall), 32'd1);
    step();
    step();
    check("cnt_in_reset", bus.stall_cnt, 32'd0);
    reset = 1;
    clear_inputs();
    step();

    // Load-use and $0 cases.
    set_load_use(2);
    #1 check("load_use_stall", 32'(bus.stall), 32'd1);
    step();
    set_load_use(1);
    #1 check("load_use_ok", 32'(bus.stall), 32'd0);
    step();
    clear_inputs();
    bus.E_dst = 5'd0; bus.E_tnew = 2'd2; bus.D_rs = 5'd0; bus.D_rs_used = 1;
    bus.M_dst = 5'd0; bus.M_tnew = 2'd3;
    #1 check("reg0_no_stall", 32'(bus.stall), 32'd0);
    step();
    clear_inputs();
    bus.M_dst = 5'd9; bus.M_tnew = 2'd1; bus.D_rt = 5'd9; bus.D_rt_used = 1;
    #1 check("m_stage_rt", 32'(bus.stall), 32'd1);
    step();
    clear_inputs();

    // Multiply: 5 busy cycles, done on the 6th, D_md stalls from the start cycle on.
    bus.D_md = 1; bus.E_md_start = 1; bus.E_md_div = 0;
    #1 check("mult_start_stall", 32'(bus.stall), 32'd1);
    step();
    bus.E_md_start = 0;
    nb = 0;
    while (bus.md_busy && nb < 20) begin
      check("mult_busy_stall", 32'(bus.stall), 32'd1);
      nb++;
      step();
    end
    check("mult_busy_len", 32'(nb), 32'(MULT_L));
    check("mult_done", 32'(bus.md_done), 32'd1);
    step();
    bus.D_md = 0;
    step();

    // Divide with a second start at busy cycle 3: no reload, busy still lasts 10.
    bus.E_md_start = 1; bus.E_md_div = 1;
    step();
    bus.E_md_start = 0;
    nb = 0;
    while (bus.md_busy && nb < 30) begin
      nb++;
      bus.E_md_start = (nb == 3);
      bus.E_md_div   = (nb != 3);
      step();
    end
    bus.E_md_start = 0;
    check("div_busy_len", 32'(nb), 32'(DIV_L));
    step();
    step();

    // Reset mid-division at busy cycle 4: everything clears and nothing resumes.
    bus.E_md_start = 1; bus.E_md_div = 1; bus.D_md = 1;
    step();
    bus.E_md_start = 0;
    for (int i = 0; i < 3; i++) step();
    reset = 0;
    #1;
    check("rst_busy", 32'(bus.md_busy), 32'd0);
    check("rst_cnt", bus.stall_cnt, 32'd0);
    check("rst_done", 32'(bus.md_done), 32'd0);
    step();
    reset = 1;
    for (int i = 0; i < 14; i++) step();
    bus.D_md = 0;

    // Random traffic over a small register set to provoke frequent hazards.
    for (int i = 0; i < 400; i++) begin
      bus.D_rs = 5'($urandom_range(0, 3));  bus.D_rt = 5'($urandom_range(0, 3));
      bus.D_rs_used = 1'($urandom);         bus.D_rt_used = 1'($urandom);
      bus.D_tuse_rs = 2'($urandom);         bus.D_tuse_rt = 2'($urandom);
      bus.E_dst = 5'($urandom_range(0, 3)); bus.M_dst = 5'($urandom_range(0, 3));
      bus.E_tnew = 2'($urandom);            bus.M_tnew = 2'($urandom);
      bus.D_md = ($urandom_range(0, 3) == 0);
      bus.E_md_start = ($urandom_range(0, 7) == 0);
      bus.E_md_div = 1'($urandom);
      if (i == 200) reset = 0;
      if (i == 203) reset = 1;
      step();
    end
    clear_inputs();
    for (int i = 0; i < 12; i++) step();

    // Saturation: preload the counter near the top and hold a stall.
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    cnt_m = 32'hFFFF_FFFE;
    set_load_use(2);
    for (int i = 0; i < 3; i++) step();
    check("sat_cnt", bus.stall_cnt, 32'hFFFF_FFFF);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
